// File: rtl/rca2_bist_ctrl_pkg.sv
// Shared types and constants for the 2-RCA BIST sequencer.
package rca2_pkg;

    localparam int unsigned N_SLICE = 4;
    localparam int unsigned N_PAT   = 8;
    localparam int unsigned PAT_W   = 3;
    localparam int unsigned SET_W   = 4;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned DFT_MAX = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        APPLY,
        SAMPLE,
        DONE
    } state_e;

    // Pattern counter bit order seen by the slices.
    typedef struct packed {
        logic a;
        logic b;
        logic cin;
    } pat_t;

    function automatic logic [CNT_W-1:0] popcnt(input logic [N_SLICE-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(N_SLICE); i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rca2_bist_ctrl_if.sv
// Slice pattern/response bus and select-generator control between BIST and datapath.
interface rca2_bist_if;
    import rca2_pkg::*;

    logic [N_SLICE-1:0]   slc_sum;
    logic [N_SLICE-1:0]   slc_cout;
    logic [N_SLICE-1:0]   slc_a;
    logic [N_SLICE-1:0]   slc_b;
    logic [N_SLICE-1:0]   slc_cin;
    logic                 init;
    logic                 test;
    logic [2*N_SLICE-1:0] comp;

    modport master (
        input  slc_sum, slc_cout,
        output slc_a, slc_b, slc_cin, init, test, comp
    );

    modport slave (
        output slc_sum, slc_cout,
        input  slc_a, slc_b, slc_cin, init, test, comp
    );

endinterface

// File: rtl/rca2_bist_ctrl_fa_golden.sv
// Reference full adder that every slice response is compared against.
module rca2_fa_golden (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/rca2_bist_ctrl.sv
// BIST sequencer for the 2-RCA datapath: sweeps all 8 patterns over 4 slices, builds a fault map.
// Optional periodic self-retest is enabled with RCA2_BIST_PERIODIC_EN.
module rca2_bist_ctrl
    import rca2_pkg::*;
#(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned PERIOD = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    rca2_bist_if.master        bus,
    output logic               busy,
    output logic               done,
    output logic [N_SLICE-1:0] fault_map,
    output logic [CNT_W-1:0]   fault_cnt,
    output logic               uncorr
);

    if (SETTLE < 1 || SETTLE > 15 || PERIOD < 2) begin : g_bad_param
        $error("rca2_bist_ctrl: SETTLE must be 1..15 and PERIOD at least 2");
    end

    state_e               state_q, state_d;
    logic [SET_W-1:0]     cnt_q, cnt_d;
    logic [PAT_W-1:0]     pat_q, pat_d;
    logic [N_SLICE-1:0]   map_q, map_d;
    logic [N_SLICE-1:0]   slc_a_q, slc_a_d, slc_b_q, slc_b_d, slc_cin_q, slc_cin_d;
    logic                 init_q, init_d, test_q, test_d;
    logic                 busy_q, busy_d, done_q, done_d, uncorr_q, uncorr_d;
    logic [2*N_SLICE-1:0] comp_q, comp_d;
    logic [N_SLICE-1:0]   fault_map_q, fault_map_d;
    logic [CNT_W-1:0]     fault_cnt_q, fault_cnt_d;
    logic                 gold_sum, gold_cout, trig_c;
    pat_t                 pat_cur, pat_nxt;

    assign pat_cur = pat_t'(pat_q);
    assign pat_nxt = pat_t'(pat_d);

    rca2_fa_golden u_golden (
        .a    (pat_cur.a),
        .b    (pat_cur.b),
        .cin  (pat_cur.cin),
        .sum  (gold_sum),
        .cout (gold_cout)
    );

`ifdef RCA2_BIST_PERIODIC_EN
    localparam int unsigned PER_W = $clog2(PERIOD);

    logic [PER_W-1:0] per_q, per_d;
    logic             pend_q, pend_d, per_hit;

    // Free-running retest timer; a hit outside IDLE is remembered until IDLE.
    always_comb begin
        per_hit = (per_q == PER_W'(PERIOD - 1));
        per_d   = per_hit ? '0 : per_q + PER_W'(1);
        pend_d  = pend_q;
        if (state_q == DONE) begin
            per_d = '0;
        end
        if (state_q == IDLE) begin
            pend_d = 1'b0;
        end else if (per_hit) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            per_q  <= per_d;
            pend_q <= pend_d;
        end
    end

    assign trig_c = start | per_hit | pend_q;
`else
    assign trig_c = start;
`endif

    // Sequencing: next state, counters and fault map.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        map_d   = map_q;
        unique case (state_q)
            IDLE: begin
                if (trig_c) state_d = CLR;
            end
            CLR: begin
                state_d = APPLY;
                cnt_d   = '0;
                pat_d   = '0;
                map_d   = '0;
            end
            APPLY: begin
                if (cnt_q == SET_W'(SETTLE - 1)) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SET_W'(1);
                end
            end
            SAMPLE: begin
                map_d = map_q | comp_q[N_SLICE-1:0] | comp_q[2*N_SLICE-1:N_SLICE];
                if (pat_q == PAT_W'(N_PAT - 1)) begin
                    state_d = DONE;
                end else begin
                    pat_d   = pat_q + PAT_W'(1);
                    state_d = APPLY;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs derived from the upcoming state so they align with it.
    always_comb begin
        init_d      = (state_d == CLR);
        test_d      = (state_d == APPLY) || (state_d == SAMPLE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        comp_d      = '0;
        slc_a_d     = slc_a_q;
        slc_b_d     = slc_b_q;
        slc_cin_d   = slc_cin_q;
        fault_map_d = fault_map_q;
        fault_cnt_d = fault_cnt_q;
        uncorr_d    = uncorr_q;
        if (state_d == SAMPLE) begin
            comp_d = {bus.slc_cout ^ {N_SLICE{gold_cout}}, bus.slc_sum ^ {N_SLICE{gold_sum}}};
        end
        if (state_d == APPLY && state_q != APPLY) begin
            slc_a_d   = {N_SLICE{pat_nxt.a}};
            slc_b_d   = {N_SLICE{pat_nxt.b}};
            slc_cin_d = {N_SLICE{pat_nxt.cin}};
        end
        if (state_d == DONE) begin
            fault_map_d = map_d;
            fault_cnt_d = popcnt(map_d);
            uncorr_d    = (fault_cnt_d > CNT_W'(DFT_MAX));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pat_q       <= '0;
            map_q       <= '0;
            slc_a_q     <= '0;
            slc_b_q     <= '0;
            slc_cin_q   <= '0;
            init_q      <= 1'b1;
            test_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            comp_q      <= '0;
            fault_map_q <= '0;
            fault_cnt_q <= '0;
            uncorr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            map_q       <= map_d;
            slc_a_q     <= slc_a_d;
            slc_b_q     <= slc_b_d;
            slc_cin_q   <= slc_cin_d;
            init_q      <= init_d;
            test_q      <= test_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            comp_q      <= comp_d;
            fault_map_q <= fault_map_d;
            fault_cnt_q <= fault_cnt_d;
            uncorr_q    <= uncorr_d;
        end
    end

    assign bus.slc_a   = slc_a_q;
    assign bus.slc_b   = slc_b_q;
    assign bus.slc_cin = slc_cin_q;
    assign bus.init    = init_q;
    assign bus.test    = test_q;
    assign bus.comp    = comp_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fault_map   = fault_map_q;
    assign fault_cnt   = fault_cnt_q;
    assign uncorr      = uncorr_q;

endmodule

// File: tb/tb_rca2_bist_ctrl.sv
// Directed bench for rca2_bist_ctrl: slice models with injectable faults, hand-derived expectations.
module tb_rca2_bist_ctrl;
    import rca2_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, uncorr;
    logic [3:0] fault_map;
    logic [2:0] fault_cnt;
    logic [3:0] sum_sa0 = '0, sum_inv = '0, cout_sa1 = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rca2_bist_if bus();

    // Four slice models driven by the broadcast pattern, with fault injection.
    assign bus.slc_sum  = ((bus.slc_a ^ bus.slc_b ^ bus.slc_cin) ^ sum_inv) & ~sum_sa0;
    assign bus.slc_cout = (bus.slc_a & bus.slc_b) | (bus.slc_a & bus.slc_cin)
                        | (bus.slc_b & bus.slc_cin) | cout_sa1;

    rca2_bist_ctrl #(.SETTLE(2), .PERIOD(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .fault_map (fault_map),
        .fault_cnt (fault_cnt),
        .uncorr    (uncorr)
    );

    int         done_cyc, done_n, init_n;
    logic [7:0] comp_at [8];
    logic       test_c1, test_c2, test_c26, busy_c27, init_c28;
    logic [3:0] fm_c1, a_c27;
    logic [2:0] pidx;
    bit         found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One run from a start request; cycle k is the k-th falling edge after the sampling edge.
    task automatic run_seq(input bit hold);
        done_cyc = 0;
        done_n   = 0;
        init_n   = 0;
        for (int p = 0; p < 8; p++) comp_at[p] = '0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (k <= 26 && bus.init) init_n++;
            if (done) begin
                done_n++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (bus.comp != '0) begin
                pidx = {bus.slc_a[0], bus.slc_b[0], bus.slc_cin[0]};
                comp_at[pidx] = comp_at[pidx] | bus.comp;
            end
            if (k == 1)  begin test_c1 = bus.test; fm_c1 = fault_map; end
            if (k == 2)  test_c2 = bus.test;
            if (k == 26) test_c26 = bus.test;
            if (k == 27) begin busy_c27 = busy; a_c27 = bus.slc_a; end
            if (k == 28) init_c28 = bus.init;
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_init", 32'(bus.init), 32'd1);
        chk("rst_test", 32'(bus.test), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_comp", 32'(bus.comp), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("init_fall", 32'(bus.init), 32'd0);

        // Fault-free run
        run_seq(1'b0);
        chk("clean_done_cyc", 32'(done_cyc), 32'd26);
        chk("clean_done_n", 32'(done_n), 32'd1);
        chk("clean_init_n", 32'(init_n), 32'd1);
        chk("clean_test_c1", 32'(test_c1), 32'd0);
        chk("clean_test_c2", 32'(test_c2), 32'd1);
        chk("clean_test_c26", 32'(test_c26), 32'd0);
        chk("clean_busy_c27", 32'(busy_c27), 32'd0);
        chk("clean_pat_hold", 32'(a_c27), 32'hF);
        for (int p = 0; p < 8; p++) chk($sformatf("clean_comp_p%0d", p), 32'(comp_at[p]), 32'd0);
        chk("clean_map", 32'(fault_map), 32'h0);
        chk("clean_cnt", 32'(fault_cnt), 32'd0);
        chk("clean_uncorr", 32'(uncorr), 32'd0);

        // Slice 1 sum stuck-at-0: visible where golden sum is 1 (pat 1,2,4,7)
        sum_sa0 = 4'b0010;
        run_seq(1'b0);
        for (int p = 0; p < 8; p++)
            chk($sformatf("s1sa0_comp_p%0d", p), 32'(comp_at[p]),
                (p == 1 || p == 2 || p == 4 || p == 7) ? 32'h02 : 32'h00);
        chk("s1sa0_map", 32'(fault_map), 32'h2);
        chk("s1sa0_cnt", 32'(fault_cnt), 32'd1);
        chk("s1sa0_uncorr", 32'(uncorr), 32'd0);

        // Slice 0 cout stuck-at-1 (pat 0,1,2,4) and slice 3 sum inverted (all pats)
        sum_sa0  = 4'b0000;
        cout_sa1 = 4'b0001;
        sum_inv  = 4'b1000;
        run_seq(1'b0);
        chk("mix_map_held_in_clr", 32'(fm_c1), 32'h2);
        for (int p = 0; p < 8; p++)
            chk($sformatf("mix_comp_p%0d", p), 32'(comp_at[p]),
                (p == 0 || p == 1 || p == 2 || p == 4) ? 32'h18 : 32'h08);
        chk("mix_map", 32'(fault_map), 32'h9);
        chk("mix_cnt", 32'(fault_cnt), 32'd2);
        chk("mix_uncorr", 32'(uncorr), 32'd0);

        // Three slices with sum stuck-at-0
        cout_sa1 = 4'b0000;
        sum_inv  = 4'b0000;
        sum_sa0  = 4'b0111;
        run_seq(1'b0);
        for (int p = 0; p < 8; p++)
            chk($sformatf("tri_comp_p%0d", p), 32'(comp_at[p]),
                (p == 1 || p == 2 || p == 4 || p == 7) ? 32'h07 : 32'h00);
        chk("tri_map", 32'(fault_map), 32'h7);
        chk("tri_cnt", 32'(fault_cnt), 32'd3);
        chk("tri_uncorr", 32'(uncorr), 32'd1);

        // Reset during APPLY of pattern 4
        sum_sa0 = 4'b0000;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (bus.test && bus.slc_a == 4'hF && bus.slc_b == 4'h0 && bus.slc_cin == 4'h0 && bus.comp == '0)
                found = 1'b1;
        end
        chk("abort_reached_pat4", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_init", 32'(bus.init), 32'd1);
        chk("abort_test", 32'(bus.test), 32'd0);
        chk("abort_comp", 32'(bus.comp), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_map_lost", 32'(fault_map), 32'h0);
        chk("abort_uncorr_lost", 32'(uncorr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        chk("abort_no_done", 32'(done_n), 32'd0);
        run_seq(1'b0);
        chk("rerun_done_cyc", 32'(done_cyc), 32'd26);
        for (int p = 0; p < 8; p++) chk($sformatf("rerun_comp_p%0d", p), 32'(comp_at[p]), 32'd0);
        chk("rerun_map", 32'(fault_map), 32'h0);

        // start held high across the run
        run_seq(1'b1);
        chk("hold_init_n", 32'(init_n), 32'd1);
        chk("hold_done_cyc", 32'(done_cyc), 32'd26);
        chk("hold_busy_c27", 32'(busy_c27), 32'd0);
        chk("hold_restart", 32'(init_c28), 32'd1);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        chk("hold_second_done", 32'(found), 32'd1);
        repeat (4) @(negedge clk);
        chk("hold_idle_after", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rca2_bist_ctrl.md
# rca2_bist_ctrl

Built-in self-test sequencer for the double-fault-tolerant 2-RCA datapath. Sits directly upstream of the RCA mux select generator and drives its `init`, `test` and `comp[7:0]` inputs. It exhaustively exercises the four full-adder slices with all eight input patterns and compares each slice against a golden full adder. It flags sum and carry mismatches per slice, and reports its own fault map and count.

## Interface

Parameters:
- `SETTLE`, default 2: cycles a pattern is held before sampling; legal range 1..15.
- `PERIOD`, default 1024: auto-retest interval in cycles. Used only when `RCA2_BIST_PERIODIC_EN` is defined.

Ports:
- `clk`  in  1  : single system clock, rising edge.
- `rst_n`  in  1  : asynchronous, active-low reset.
- `start`  in  1  : request a test run; sampled in IDLE only.
- `slc_sum`  in  4  : sum output of slices 3..0.
- `slc_cout`  in  4  : carry output of slices 3..0.
- `slc_a`, `slc_b`, `slc_cin`  out  4 each  : pattern broadcast to all slices.
- `init`  out  1  : clear pulse to the select generator.
- `test`  out  1  : test-mode window to the select generator.
- `comp`  out  8  : mismatch strobes. `comp[i]` is a sum mismatch on slice i; `comp[4+i]` is a carry mismatch on slice i.
- `busy`  out  1  : run in progress.
- `done`  out  1  : one-cycle end-of-run pulse.
- `fault_map`  out  4  : per-slice accumulated fault.
- `fault_cnt`  out  3  : popcount of `fault_map`.
- `uncorr`  out  1  : more than two slices faulty.

## Operation

- Pattern counter `pat[2:0]` maps to {a,b,cin}. All bits of `slc_a`/`slc_b`/`slc_cin` are copies of `pat[2]`/`pat[1]`/`pat[0]`.
- Golden model: `sum = a^b^cin`; `cout = ab|acin|bcin`.
- States:
  - **IDLE**: outputs quiescent. On `start`, go to CLR.
  - **CLR**: `init=1` for exactly one cycle; `pat` and settle counter cleared; internal map cleared. Go to APPLY.
  - **APPLY**: `test=1`, pattern driven, `comp=0`. Stays for `SETTLE` cycles, then goes to SAMPLE.
  - **SAMPLE**: `test=1` for one cycle. `comp[i] = slc_sum[i]^gold_sum`; `comp[4+i] = slc_cout[i]^gold_cout`. Internal map ORs in `comp[i]|comp[4+i]`. If `pat==7`, go to DONE; otherwise increment `pat` and go to APPLY.
  - **DONE**: `test=0`, `done=1`. `fault_map`, `fault_cnt` and `uncorr` are registered here. Go to IDLE.
- `comp` is nonzero only in SAMPLE, because the downstream accumulator ORs `comp` at every edge while `test` is high.
- `busy=1` in CLR, APPLY, SAMPLE and DONE.
- `start` outside IDLE is ignored, and is not queued.
- `fault_map`, `fault_cnt` and `uncorr` hold their values until the next DONE. They are not cleared at CLR.

## Timing

- Reset values while `rst_n` is low: `init=1`, which clears the downstream block during reset. All other outputs are 0 and the state is IDLE.
- `init` falls on the first rising edge after `rst_n` deasserts.
- Run length from the `start` sample edge: 1 (CLR) + 8×(`SETTLE`+1) + 1 (DONE) cycles. With the default `SETTLE`, `done` is high in cycle 26.
- `test` rises the cycle after `init` falls and falls on entry to DONE. Downstream selects are valid from DONE onward.
- Pattern outputs change only on APPLY entry. They are stable through SAMPLE, and then hold the last pattern.
- Reset mid-run aborts immediately: outputs take their reset values, no `done` is produced, and status is lost.

## Configuration

- `RCA2_BIST_PERIODIC_EN` **defined**:
  - A free-running counter, cleared at DONE and at reset, triggers an internal start when it reaches `PERIOD-1` in IDLE.
  - If that trigger lands outside IDLE, it is deferred until IDLE is reached.
  - An external `start` also works.
- `RCA2_BIST_PERIODIC_EN` **undefined**:
  - The counter is not present.
  - Runs occur only on `start`.

## Structure

- Package `rca2_pkg` holds:
  - `N_SLICE=4`, `N_PAT=8`;
  - the state enum: IDLE, CLR, APPLY, SAMPLE, DONE;
  - `DFT_MAX=2`, the correctable-fault limit used for `uncorr`.
- Sub-module `rca2_fa_golden`: combinational golden full adder (a, b, cin to sum, cout), instantiated once.
- Everything else lives in the top: FSM, pattern and settle counters, compare, map and popcount.

## Test plan

- **Fault-free slices, `start` pulse:**
  - `comp` stays 0 throughout;
  - `done` is high in cycle 26;
  - `fault_map=0000`, `fault_cnt=0`, `uncorr=0`.
- **Slice 1 sum stuck-at-0:**
  - `comp[1]` pulses in SAMPLE for `pat`=1, 2, 4 and 7 only;
  - `fault_map=0010`, `fault_cnt=1`.
- **Slice 0 cout stuck-at-1 and slice 3 sum inverted:**
  - `comp[4]` is seen at `pat`=0, 1, 2 and 4;
  - `comp[3]` is seen at every pattern;
  - `fault_map=1001`, `fault_cnt=2`, `uncorr=0`.
- **Three slices stuck-at-0 on sum (slices 0, 1, 2):**
  - `fault_cnt=3`, `uncorr=1`.
- **`rst_n` low during APPLY of `pat`=4:**
  - `init=1`, `test=0`, `comp=0` and `busy=0` immediately;
  - no `done`;
  - the next `start` runs a full 26-cycle clean sequence.
- **`start` held high for the whole run:**
  - exactly one CLR;
  - after DONE, a second run begins;
  - with `RCA2_BIST_PERIODIC_EN` and `PERIOD=64`, idle runs start 64 cycles after each `done`.
